des_core_sched: RTL

- Sequences a single iterative DES encryption core (des_top) and shares it between two requesters on valid/ready handshakes.
- Per job: arbitrates, latches the operands, restarts the core through its active-low per-job reset, waits for `completed` and returns the ciphertext to the winning requester.
- Sits between the system request fabric and des_top.
- Adds timeout protection and a completed-job counter.

---
 rtl/des_sched_pkg.sv | 15 +
 rtl/rr_arb2.sv | 22 ++
 rtl/des_core_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/des_sched_pkg.sv
// rtl/des_sched_pkg.sv - shared types and constants for the DES core scheduler
package des_sched_pkg;

    localparam int DES_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RESP
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, pointer held by the caller
module rr_arb2
    import des_sched_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    pointer,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    always_comb begin
        grant    = '0;
        grant_id = pointer;
        if (valid[pointer]) begin
            grant[pointer] = 1'b1;
        end else if (valid[~pointer]) begin
            grant_id        = ~pointer;
            grant[~pointer] = 1'b1;
        end
    end

endmodule

// File: rtl/des_core_sched.sv
// rtl/des_core_sched.sv - shares one iterative DES core between two requesters
module des_core_sched
    import des_sched_pkg::*;
#(
    parameter int DES_W       = 64,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*DES_W-1:0]   req_plain,
    input  logic [2*DES_W-1:0]   req_key,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [DES_W-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic                 core_rst_n,
    output logic [DES_W-1:0]     core_plain,
    output logic [DES_W-1:0]     core_key,
    input  logic [DES_W-1:0]     core_encrypted,
    input  logic                 core_completed,
    output logic                 busy,
    output logic [CNT_W-1:0]     jobs_done
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    state_t           state, state_next;
    req_id_t          ptr, gnt_id, arb_id;
    logic [1:0]       arb_grant;
    logic [TMO_W-1:0] tmo_cnt;
    logic             accept, rsp_fire, timed_out;

    rr_arb2 u_arb (
        .valid    (req_valid),
        .pointer  (ptr),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    assign timed_out = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign busy      = (state != ST_IDLE);

    // req_ready is combinational, so it is also gated by rst to stay 0 during reset
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst && (|req_valid)) begin
                    req_ready  = arb_grant;
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: state_next = ST_RUN;
            ST_RUN: begin
                if (core_completed || timed_out)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[gnt_id] = 1'b1;
                if (rsp_ready[gnt_id]) begin
                    rsp_fire   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // core_rst_n is registered from the next state so the core sees exactly the LOAD cycle low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rst_n <= 1'b0;
            ptr        <= 1'b0;
            gnt_id     <= 1'b0;
            core_plain <= '0;
            core_key   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            jobs_done  <= '0;
            tmo_cnt    <= '0;
        end else begin
            core_rst_n <= (state_next != ST_LOAD);
            if (accept) begin
                gnt_id     <= arb_id;
                core_plain <= arb_id ? req_plain[2*DES_W-1:DES_W] : req_plain[DES_W-1:0];
                core_key   <= arb_id ? req_key[2*DES_W-1:DES_W]   : req_key[DES_W-1:0];
            end
            if (state == ST_LOAD)
                tmo_cnt <= '0;
            if (state == ST_RUN) begin
                if (core_completed) begin
                    rsp_data  <= core_encrypted;
                    rsp_err   <= 1'b0;
                    jobs_done <= jobs_done + CNT_W'(1);
                end else if (timed_out) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
            if (rsp_fire)
                ptr <= ~gnt_id;
        end
    end

endmodule
